// File: rtl/rgals_pkg.sv
// Shared divisor type and helpers for the RGALS crossing scheduler.
package rgals_pkg;

   localparam int unsigned c_div_width = 8;

   typedef logic [c_div_width-1:0] div_t;

   // A programmed divisor of 0 behaves as 1 (tick every base cycle).
   function automatic logic [31:0] f_norm_div(input logic [31:0] i_div);
      return (i_div == '0) ? 32'd1 : i_div;
   endfunction

endpackage

// File: rtl/rgals_sched_fifo.sv
// Per-direction message buffer; push/pop enables are pre-qualified by the parent.
module rgals_sched_fifo
   import rgals_pkg::*;
#(
   parameter int unsigned p_data_width = 32,
   parameter int unsigned p_depth      = 2
) (
   input  logic                    clk,
   input  logic                    i_rst_n,
   input  logic                    i_push,
   input  logic [p_data_width-1:0] i_data,
   input  logic                    i_pop,
   output logic                    o_full,
   output logic                    o_empty,
   output logic [p_data_width-1:0] o_head
);

   localparam int unsigned c_aw = $clog2(p_depth);
   localparam logic [c_aw:0] c_full = (c_aw+1)'(p_depth);

   logic [p_data_width-1:0] r_mem [p_depth];
   logic [c_aw-1:0]         r_wr_ptr;
   logic [c_aw-1:0]         r_rd_ptr;
   logic [c_aw:0]           r_count;

   assign o_full  = (r_count == c_full);
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/rgals_sched_channel.sv
// RGALS crossing scheduler: divided-domain ticks, joint safe strobe and
// safe-cycle-gated bidirectional message buffers with runtime divisors.
module rgals_sched_channel
   import rgals_pkg::*;
#(
   parameter int unsigned p_data_width     = 32,
   parameter int unsigned p_depth          = 2,
   parameter int unsigned p_div_width      = c_div_width,
   parameter int unsigned p_div_left_init  = 3,
   parameter int unsigned p_div_right_init = 5
) (
   input  logic                    clk,
   input  logic                    reset_n,

   input  logic                    cfg_val,
   output logic                    cfg_rdy,
   input  logic [p_div_width-1:0]  cfg_div_left,
   input  logic [p_div_width-1:0]  cfg_div_right,

   output logic                    tick_left,
   output logic                    tick_right,
   output logic                    safe,

   input  logic                    l2r_enq_val,
   output logic                    l2r_enq_rdy,
   input  logic [p_data_width-1:0] l2r_enq_msg,
   output logic                    l2r_deq_val,
   input  logic                    l2r_deq_rdy,
   output logic [p_data_width-1:0] l2r_deq_msg,

   input  logic                    r2l_enq_val,
   output logic                    r2l_enq_rdy,
   input  logic [p_data_width-1:0] r2l_enq_msg,
   output logic                    r2l_deq_val,
   input  logic                    r2l_deq_rdy,
   output logic [p_data_width-1:0] r2l_deq_msg
);

   logic [p_div_width-1:0]  r_cnt_l;
   logic [p_div_width-1:0]  r_cnt_r;
   logic [p_div_width-1:0]  r_div_l;
   logic [p_div_width-1:0]  r_div_r;

   logic [p_div_width-1:0]  w_div_l;
   logic [p_div_width-1:0]  w_div_r;
   logic                    w_cfg_fire;

   logic                    w_l2r_full;
   logic                    w_l2r_empty;
   logic [p_data_width-1:0] w_l2r_head;
   logic                    w_l2r_push;
   logic                    w_l2r_pop;

   logic                    w_r2l_full;
   logic                    w_r2l_empty;
   logic [p_data_width-1:0] w_r2l_head;
   logic                    w_r2l_push;
   logic                    w_r2l_pop;

   assign w_div_l = p_div_width'(f_norm_div(32'(r_div_l)));
   assign w_div_r = p_div_width'(f_norm_div(32'(r_div_r)));

   // Every strobe and handshake output is held low while reset is asserted.
   assign tick_left  = reset_n && (r_cnt_l == '0);
   assign tick_right = reset_n && (r_cnt_r == '0);
   assign safe       = tick_left && tick_right;

   assign cfg_rdy    = safe && w_l2r_empty && w_r2l_empty;
   assign w_cfg_fire = cfg_val && cfg_rdy;

   assign l2r_enq_rdy = reset_n && !w_l2r_full;
   assign w_l2r_push  = l2r_enq_val && l2r_enq_rdy && tick_left;
   assign l2r_deq_val = safe && !w_l2r_empty;
   assign l2r_deq_msg = l2r_deq_val ? w_l2r_head : '0;
   assign w_l2r_pop   = l2r_deq_val && l2r_deq_rdy;

   assign r2l_enq_rdy = reset_n && !w_r2l_full;
   assign w_r2l_push  = r2l_enq_val && r2l_enq_rdy && tick_right;
   assign r2l_deq_val = safe && !w_r2l_empty;
   assign r2l_deq_msg = r2l_deq_val ? w_r2l_head : '0;
   assign w_r2l_pop   = r2l_deq_val && r2l_deq_rdy;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt_l <= '0;
         r_cnt_r <= '0;
         r_div_l <= p_div_width'(p_div_left_init);
         r_div_r <= p_div_width'(p_div_right_init);
      end else if (w_cfg_fire) begin
         r_cnt_l <= '0;
         r_cnt_r <= '0;
         r_div_l <= cfg_div_left;
         r_div_r <= cfg_div_right;
      end else begin
         r_cnt_l <= (r_cnt_l >= w_div_l - 1'b1) ? '0 : r_cnt_l + 1'b1;
         r_cnt_r <= (r_cnt_r >= w_div_r - 1'b1) ? '0 : r_cnt_r + 1'b1;
      end
   end

   rgals_sched_fifo #(
      .p_data_width (p_data_width),
      .p_depth      (p_depth)
   ) u_l2r_fifo (
      .clk     (clk),
      .i_rst_n (reset_n),
      .i_push  (w_l2r_push),
      .i_data  (l2r_enq_msg),
      .i_pop   (w_l2r_pop),
      .o_full  (w_l2r_full),
      .o_empty (w_l2r_empty),
      .o_head  (w_l2r_head)
   );

   rgals_sched_fifo #(
      .p_data_width (p_data_width),
      .p_depth      (p_depth)
   ) u_r2l_fifo (
      .clk     (clk),
      .i_rst_n (reset_n),
      .i_push  (w_r2l_push),
      .i_data  (r2l_enq_msg),
      .i_pop   (w_r2l_pop),
      .o_full  (w_r2l_full),
      .o_empty (w_r2l_empty),
      .o_head  (w_r2l_head)
   );

endmodule

// File: tb/tb_rgals_sched_channel.sv
// Scoreboard bench for rgals_sched_channel against a cycle-count reference model.
module tb_rgals_sched_channel;

   localparam int unsigned W  = 32;
   localparam int unsigned D  = 2;
   localparam int unsigned DW = 8;

   logic          clk;
   logic          reset_n;
   logic          cfg_val;
   logic          cfg_rdy;
   logic [DW-1:0] cfg_div_left;
   logic [DW-1:0] cfg_div_right;
   logic          tick_left;
   logic          tick_right;
   logic          safe;
   logic          l2r_enq_val;
   logic          l2r_enq_rdy;
   logic [W-1:0]  l2r_enq_msg;
   logic          l2r_deq_val;
   logic          l2r_deq_rdy;
   logic [W-1:0]  l2r_deq_msg;
   logic          r2l_enq_val;
   logic          r2l_enq_rdy;
   logic [W-1:0]  r2l_enq_msg;
   logic          r2l_deq_val;
   logic          r2l_deq_rdy;
   logic [W-1:0]  r2l_deq_msg;

   rgals_sched_channel #(
      .p_data_width     (W),
      .p_depth          (D),
      .p_div_width      (DW),
      .p_div_left_init  (3),
      .p_div_right_init (5)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .cfg_val       (cfg_val),
      .cfg_rdy       (cfg_rdy),
      .cfg_div_left  (cfg_div_left),
      .cfg_div_right (cfg_div_right),
      .tick_left     (tick_left),
      .tick_right    (tick_right),
      .safe          (safe),
      .l2r_enq_val   (l2r_enq_val),
      .l2r_enq_rdy   (l2r_enq_rdy),
      .l2r_enq_msg   (l2r_enq_msg),
      .l2r_deq_val   (l2r_deq_val),
      .l2r_deq_rdy   (l2r_deq_rdy),
      .l2r_deq_msg   (l2r_deq_msg),
      .r2l_enq_val   (r2l_enq_val),
      .r2l_enq_rdy   (r2l_enq_rdy),
      .r2l_enq_msg   (r2l_enq_msg),
      .r2l_deq_val   (r2l_deq_val),
      .r2l_deq_rdy   (r2l_deq_rdy),
      .r2l_deq_msg   (r2l_deq_msg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: cycles since the counters were last zeroed, plus contents.
   int          k;
   int          m_dl;
   int          m_dr;
   logic [W-1:0] m_l2r[$];
   logic [W-1:0] m_r2l[$];
   logic [W-1:0] sb_l2r[$];
   logic [W-1:0] sb_r2l[$];
   int          n_pass;
   int          n_total;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int norm(input int d);
      return (d == 0) ? 1 : d;
   endfunction

   // Called just after inputs change on a negedge: checks outputs, advances model.
   task automatic step(output bit fired);
      bit tl, tr, sf, crdy, lrdy, rrdy, lval, rval;
      fired = 1'b0;
      #1;
      if (!reset_n) begin
         {tl, tr, sf, crdy, lrdy, rrdy, lval, rval} = '0;
      end else begin
         tl   = (k % norm(m_dl)) == 0;
         tr   = (k % norm(m_dr)) == 0;
         sf   = tl && tr;
         crdy = sf && m_l2r.size() == 0 && m_r2l.size() == 0;
         lrdy = m_l2r.size() < D;
         rrdy = m_r2l.size() < D;
         lval = sf && m_l2r.size() > 0;
         rval = sf && m_r2l.size() > 0;
      end
      check("status{tl,tr,safe,cfg_rdy,l_rdy,r_rdy,l_val,r_val}",
            {tick_left, tick_right, safe, cfg_rdy, l2r_enq_rdy, r2l_enq_rdy, l2r_deq_val, r2l_deq_val},
            {tl, tr, sf, crdy, lrdy, rrdy, lval, rval});
      if (!lval) check("l2r_msg_idle_zero", l2r_deq_msg, 0);
      if (!rval) check("r2l_msg_idle_zero", r2l_deq_msg, 0);
      #1;
      if (!reset_n) begin
         k = 0; m_dl = 3; m_dr = 5;
         m_l2r.delete(); m_r2l.delete(); sb_l2r.delete(); sb_r2l.delete();
      end else begin
         if (lval && l2r_deq_rdy) void'(m_l2r.pop_front());
         if (rval && r2l_deq_rdy) void'(m_r2l.pop_front());
         if (l2r_enq_val && lrdy && tl) begin
            m_l2r.push_back(l2r_enq_msg); sb_l2r.push_back(l2r_enq_msg);
         end
         if (r2l_enq_val && rrdy && tr) begin
            m_r2l.push_back(r2l_enq_msg); sb_r2l.push_back(r2l_enq_msg);
         end
         if (cfg_val && crdy) begin
            k = 0; m_dl = int'(cfg_div_left); m_dr = int'(cfg_div_right); fired = 1'b1;
         end else begin
            k++;
         end
      end
      @(negedge clk);
   endtask

   // Monitor: pops the expected message whenever a dequeue handshake completes.
   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (reset_n && l2r_deq_val && l2r_deq_rdy) begin
            if (sb_l2r.size() == 0) begin
               n_total++;
               $display("FAIL l2r_unexpected_deq: got msg %h expected none", l2r_deq_msg);
            end else check("l2r_deq_msg", l2r_deq_msg, sb_l2r.pop_front());
         end
         if (reset_n && r2l_deq_val && r2l_deq_rdy) begin
            if (sb_r2l.size() == 0) begin
               n_total++;
               $display("FAIL r2l_unexpected_deq: got msg %h expected none", r2l_deq_msg);
            end else check("r2l_deq_msg", r2l_deq_msg, sb_r2l.pop_front());
         end
      end
   end

   task automatic idle();
      cfg_val = 1'b0; cfg_div_left = '0; cfg_div_right = '0;
      l2r_enq_val = 1'b0; l2r_enq_msg = '0; l2r_deq_rdy = 1'b0;
      r2l_enq_val = 1'b0; r2l_enq_msg = '0; r2l_deq_rdy = 1'b0;
   endtask

   task automatic run_cfg(input int dl, input int dr);
      bit f;
      bit done;
      done = 1'b0;
      cfg_val = 1'b1; cfg_div_left = DW'(dl); cfg_div_right = DW'(dr);
      for (int i = 0; i < 200 && !done; i++) begin
         step(f);
         done = f;
      end
      cfg_val = 1'b0;
      n_total++;
      if (done) n_pass++;
      else $display("FAIL cfg_accept_timeout: got no acceptance expected acceptance within 200 cycles");
   endtask

   initial begin
      bit f;
      n_pass = 0; n_total = 0;
      k = 0; m_dl = 3; m_dr = 5;
      idle();
      reset_n = 1'b0;
      @(negedge clk);
      repeat (3) step(f);
      reset_n = 1'b1;

      // Default 3/5: single 0xA5 enqueued at cycle 3, must appear at cycle 15 only.
      l2r_deq_rdy = 1'b1;
      for (int c = 0; c < 32; c++) begin
         l2r_enq_val = (c == 3);
         l2r_enq_msg = 32'hA5;
         if (c == 15) begin
            #1;
            check("a5_at_cycle15", {l2r_deq_val, l2r_deq_msg}, {1'b1, 32'hA5});
         end
         step(f);
      end

      // Depth limit with stalled consumer, then release.
      l2r_deq_rdy = 1'b0;
      for (int c = 0; c < 40; c++) begin
         l2r_enq_val = 1'b1; l2r_enq_msg = $urandom;
         if (c == 25) l2r_deq_rdy = 1'b1;
         step(f);
      end
      l2r_enq_val = 1'b0; l2r_deq_rdy = 1'b0;
      repeat (4) step(f);

      // Divisor update blocked until buffers drain, then 2/4.
      l2r_deq_rdy = 1'b1;
      run_cfg(2, 4);
      repeat (20) step(f);

      // Divisors 0/1: everything ticks every cycle.
      run_cfg(0, 1);
      l2r_deq_rdy = 1'b1; r2l_deq_rdy = 1'b1;
      for (int c = 0; c < 12; c++) begin
         l2r_enq_val = 1'b1; l2r_enq_msg = $urandom;
         r2l_enq_val = (c % 3) != 0; r2l_enq_msg = $urandom;
         step(f);
      end

      // Reset with buffered entries.
      l2r_deq_rdy = 1'b0; r2l_deq_rdy = 1'b0;
      repeat (4) begin
         l2r_enq_msg = $urandom; r2l_enq_msg = $urandom;
         step(f);
      end
      reset_n = 1'b0;
      repeat (2) step(f);
      reset_n = 1'b1;
      idle();
      l2r_deq_rdy = 1'b1; r2l_deq_rdy = 1'b1;
      repeat (20) step(f);

      // Randomised traffic, reconfiguration and occasional reset.
      for (int c = 0; c < 3000; c++) begin
         reset_n       = ($urandom_range(0, 199) != 0);
         cfg_val       = ($urandom_range(0, 9) == 0);
         cfg_div_left  = DW'($urandom_range(0, 7));
         cfg_div_right = DW'($urandom_range(0, 7));
         l2r_enq_val   = $urandom_range(0, 1);
         l2r_enq_msg   = $urandom;
         l2r_deq_rdy   = ($urandom_range(0, 4) < 3);
         r2l_enq_val   = $urandom_range(0, 1);
         r2l_enq_msg   = $urandom;
         r2l_deq_rdy   = ($urandom_range(0, 4) < 3);
         step(f);
      end

      reset_n = 1'b1;
      idle();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
